// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the digit-serial multiplier schedule controller.
package seq_mult_pkg;

    localparam int DIGIT_W = 2;
    localparam int OPER_W  = 16;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, LAST} state_e;

    typedef logic [1:0] wcode_t;
    typedef logic [2:0] digit_idx_t;

    localparam logic [4*DIGIT_W-1:0] INIT_SIGNED = 8'h00;
    localparam logic [1:0]           CORR_SHIFT  = 2'b10;

    typedef struct packed {
        digit_idx_t sel_a;
        digit_idx_t sel_b;
        logic       count_down;
        logic       count_last2;
        logic       inv_first;
        logic       inv_second;
        logic       place_one;
        logic [1:0] shift_in;
    } sched_t;

    // N-1 for a width code, where N = 1 << wcode digits per operand.
    function automatic logic [3:0] n_minus1(input wcode_t wcode);
        return 4'((1 << wcode) - 1);
    endfunction

endpackage

// File: rtl/seq_mult_term_cnt.sv
// Column/term walker: visits (i, j = k-i) column by column, i ascending inside a column.
module seq_mult_term_cnt
    import seq_mult_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    input  wcode_t     wcode,
    output digit_idx_t idx_i,
    output digit_idx_t idx_j,
    output logic [3:0] col_k,
    output logic       first_term,
    output logic       last_term,
    output logic       last_col
);

    logic [3:0] k_q;
    logic [3:0] k_nxt;
    logic [3:0] n_m1;
    digit_idx_t i_q;
    digit_idx_t i_lo;
    digit_idx_t i_hi;

    assign n_m1  = n_minus1(wcode);
    assign k_nxt = k_q + 4'd1;
    assign i_lo  = (k_q > n_m1) ? 3'(k_q - n_m1) : 3'd0;
    assign i_hi  = (k_q < n_m1) ? 3'(k_q) : 3'(n_m1);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
            i_q <= '0;
        end else if (clear) begin
            k_q <= '0;
            i_q <= '0;
        end else if (advance) begin
            if (last_term) begin
                k_q <= k_nxt;
                i_q <= (k_nxt > n_m1) ? 3'(k_nxt - n_m1) : 3'd0;
            end else begin
                i_q <= i_q + 3'd1;
            end
        end
    end

    assign idx_i      = i_q;
    assign idx_j      = k_q[2:0] - i_q;
    assign col_k      = k_q;
    assign first_term = (i_q == i_lo);
    assign last_term  = (i_q == i_hi);
    assign last_col   = (k_q == {n_m1[2:0], 1'b0});

endmodule

// File: rtl/seq_mult_ctrl.sv
// Request handshake and per-term schedule generator for the digit-serial multiplier datapath.
//   state | meaning
//   IDLE  | ready for a request
//   LOAD  | datapath load/clear, accumulator preset
//   MAC   | one partial-product term per cycle, N*N cycles
//   DRAIN | flushes the schedule pipeline stage (MANUAL_PIPELINE only)
//   LAST  | final upper-digit output cycle
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int P               = 2,
    parameter int MAX_WIDTH       = 16,
    parameter int MANUAL_PIPELINE = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [MAX_WIDTH-1:0] req_a_i,
    input  logic [MAX_WIDTH-1:0] req_b_i,
    input  logic [1:0]           req_wcode_i,
    input  logic                 req_signed_i,
    output logic [MAX_WIDTH-1:0] a_o,
    output logic [MAX_WIDTH-1:0] b_o,
    output logic                 start_o,
    output logic [2:0]           muxSelA_o,
    output logic [2:0]           muxSelB_o,
    output logic                 countDown_o,
    output logic                 countLast2_o,
    output logic                 lastOut_o,
    output logic                 invertFirstBit_o,
    output logic                 invertSecondRow_o,
    output logic                 placeOne_o,
    output logic [1:0]           countShiftInput_o,
    output logic [4*P-1:0]       initSum_o,
    output logic                 dig_valid_o,
    output logic                 dig_last_o,
    output logic                 busy_o
);

    state_e     state_q;
    state_e     state_d;
    wcode_t     wcode_q;
    logic       signed_q;
    logic [3:0] n_m1;
    digit_idx_t cnt_i;
    digit_idx_t cnt_j;
    logic [3:0] cnt_k;
    logic       cnt_first;
    logic       cnt_last;
    logic       cnt_last_col;
    logic       i_top;
    logic       j_top;
    logic       corner;
    sched_t     sched_c;
    sched_t     sched_o;
    logic       last_out;
    logic       dig_valid_q;
    logic       dig_last_q;

    assign n_m1 = n_minus1(wcode_q);

    seq_mult_term_cnt u_term_cnt (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .clear      (state_q == LOAD),
        .advance    (state_q == MAC),
        .wcode      (wcode_q),
        .idx_i      (cnt_i),
        .idx_j      (cnt_j),
        .col_k      (cnt_k),
        .first_term (cnt_first),
        .last_term  (cnt_last),
        .last_col   (cnt_last_col)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = LOAD;
            LOAD:    state_d = MAC;
            MAC:     if (cnt_last && cnt_last_col) state_d = (MANUAL_PIPELINE != 0) ? DRAIN : LAST;
            DRAIN:   state_d = LAST;
            LAST:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Corner term (both top digits) keeps its sign weight positive, except when N=1.
    assign i_top  = ({1'b0, cnt_i} == n_m1);
    assign j_top  = ({1'b0, cnt_j} == n_m1);
    assign corner = i_top && j_top && (wcode_q != 2'd0);

    always_comb begin
        sched_c   = '0;
        start_o   = 1'b0;
        initSum_o = '0;
        last_out  = 1'b0;
        case (state_q)
            LOAD: begin
                start_o   = 1'b1;
                initSum_o = signed_q ? INIT_SIGNED : '0;
            end
            MAC: begin
                sched_c.sel_a       = cnt_i;
                sched_c.sel_b       = cnt_j;
                sched_c.count_down  = (cnt_k >= n_m1);
                sched_c.count_last2 = cnt_last;
                if (signed_q) begin
                    sched_c.inv_first  = i_top && !corner;
                    sched_c.inv_second = j_top && !corner;
                    sched_c.place_one  = cnt_first && (cnt_k == n_m1);
                    sched_c.shift_in   = (cnt_last && cnt_last_col) ? CORR_SHIFT : 2'b00;
                end
            end
            LAST:    last_out = 1'b1;
            default: ;
        endcase
    end

    generate
        if (MANUAL_PIPELINE != 0) begin : g_pipe
            sched_t sched_q;
            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    sched_q <= '0;
                end else begin
                    sched_q <= sched_c;
                end
            end
            assign sched_o = sched_q;
        end else begin : g_comb
            assign sched_o = sched_c;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            a_o      <= '0;
            b_o      <= '0;
            wcode_q  <= '0;
            signed_q <= 1'b0;
        end else if (state_q == IDLE && req_valid_i) begin
            a_o      <= req_a_i;
            b_o      <= req_b_i;
            wcode_q  <= req_wcode_i;
            signed_q <= req_signed_i;
        end
    end

    // A product digit appears one cycle after each column shift and after the final output cycle.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            dig_valid_q <= 1'b0;
            dig_last_q  <= 1'b0;
        end else begin
            dig_valid_q <= sched_o.count_last2 | last_out;
            dig_last_q  <= last_out;
        end
    end

    assign req_ready_o       = (state_q == IDLE);
    assign busy_o            = (state_q != IDLE);
    assign lastOut_o         = last_out;
    assign muxSelA_o         = sched_o.sel_a;
    assign muxSelB_o         = sched_o.sel_b;
    assign countDown_o       = sched_o.count_down;
    assign countLast2_o      = sched_o.count_last2;
    assign invertFirstBit_o  = sched_o.inv_first;
    assign invertSecondRow_o = sched_o.inv_second;
    assign placeOne_o        = sched_o.place_one;
    assign countShiftInput_o = sched_o.shift_in;
    assign dig_valid_o       = dig_valid_q;
    assign dig_last_o        = dig_last_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: instance 0 unpipelined, instance 1 with MANUAL_PIPELINE=1.
module tb_seq_mult_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  req_wcode;
    logic        req_signed;

    logic        req_ready [2];
    logic [15:0] a_o [2];
    logic [15:0] b_o [2];
    logic        start [2];
    logic [2:0]  sel_a [2];
    logic [2:0]  sel_b [2];
    logic        cnt_down [2];
    logic        cnt_last2 [2];
    logic        last_out [2];
    logic        inv_f [2];
    logic        inv_s [2];
    logic        place_one [2];
    logic [1:0]  cshift [2];
    logic [7:0]  init_sum [2];
    logic        dig_valid [2];
    logic        dig_last [2];
    logic        busy [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    seq_mult_ctrl #(.P(2), .MAX_WIDTH(16), .MANUAL_PIPELINE(0)) u_dut0 (
        .clk_i(clk_i), .rst_n(rst_n), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_a_i(req_a), .req_b_i(req_b), .req_wcode_i(req_wcode), .req_signed_i(req_signed),
        .a_o(a_o[0]), .b_o(b_o[0]), .start_o(start[0]), .muxSelA_o(sel_a[0]), .muxSelB_o(sel_b[0]),
        .countDown_o(cnt_down[0]), .countLast2_o(cnt_last2[0]), .lastOut_o(last_out[0]),
        .invertFirstBit_o(inv_f[0]), .invertSecondRow_o(inv_s[0]), .placeOne_o(place_one[0]),
        .countShiftInput_o(cshift[0]), .initSum_o(init_sum[0]), .dig_valid_o(dig_valid[0]),
        .dig_last_o(dig_last[0]), .busy_o(busy[0])
    );

    seq_mult_ctrl #(.P(2), .MAX_WIDTH(16), .MANUAL_PIPELINE(1)) u_dut1 (
        .clk_i(clk_i), .rst_n(rst_n), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_a_i(req_a), .req_b_i(req_b), .req_wcode_i(req_wcode), .req_signed_i(req_signed),
        .a_o(a_o[1]), .b_o(b_o[1]), .start_o(start[1]), .muxSelA_o(sel_a[1]), .muxSelB_o(sel_b[1]),
        .countDown_o(cnt_down[1]), .countLast2_o(cnt_last2[1]), .lastOut_o(last_out[1]),
        .invertFirstBit_o(inv_f[1]), .invertSecondRow_o(inv_s[1]), .placeOne_o(place_one[1]),
        .countShiftInput_o(cshift[1]), .initSum_o(init_sum[1]), .dig_valid_o(dig_valid[1]),
        .dig_last_o(dig_last[1]), .busy_o(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one request on instance p and checks schedule, strobes and latency.
    task automatic run_op(input int p, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] wc, input logic sg,
                          input logic [31:0] exp_prod, input logic chk_prod);
        int n, nn, t, c, pulses, lasts, lo, hi, j;
        logic [5:0]  e_sel [64];
        logic [6:0]  e_flg [64];
        logic        el, ef, es, ep;
        logic [1:0]  ec;
        logic [31:0] prod;
        logic        done;
        n  = 1 << wc;
        nn = n * n;
        t  = 0;
        for (int k = 0; k <= 2*n-2; k++) begin
            lo = (k > n-1) ? k-n+1 : 0;
            hi = (k < n-1) ? k : n-1;
            for (int i = lo; i <= hi; i++) begin
                j  = k - i;
                el = (i == hi);
                ef = sg && (i == n-1) && !((i == n-1) && (j == n-1) && (n > 1));
                es = sg && (j == n-1) && !((i == n-1) && (j == n-1) && (n > 1));
                ep = sg && (k == n-1) && (i == lo);
                ec = (sg && el && (k == 2*n-2)) ? 2'b10 : 2'b00;
                e_sel[t] = {3'(i), 3'(j)};
                e_flg[t] = {el, (k >= n-1), ef, es, ep, ec};
                t++;
            end
        end
        req_a = a; req_b = b; req_wcode = wc; req_signed = sg;
        req_valid[p] = 1'b1;
        check("ready_idle", 32'(req_ready[p]), 32'd1);
        tick();
        req_valid[p] = 1'b0;
        check("load_start", {29'd0, start[p], req_ready[p], busy[p]}, {29'd0, 3'b101});
        check("init_sum", 32'(init_sum[p]), 32'h0);
        check("captured_a", 32'(a_o[p]), 32'(a));
        pulses = dig_valid[p] ? 1 : 0;
        lasts  = 0;
        prod   = 0;
        c      = 0;
        done   = 1'b0;
        while (!done && c < 200) begin
            tick();
            c++;
            if (dig_valid[p]) begin
                pulses++;
                if (dig_last[p]) begin
                    lasts++;
                    check("dig_last_pos", pulses, 2*n);
                end
            end
            t = c - 1 - p;
            if (t >= 0 && t < nn) begin
                check("sel_ij", 32'({sel_a[p], sel_b[p]}), 32'(e_sel[t]));
                check("flags", 32'({cnt_last2[p], cnt_down[p], inv_f[p], inv_s[p], place_one[p], cshift[p]}),
                      32'(e_flg[t]));
                prod += (32'((a >> (2*sel_a[p])) & 16'h3) * 32'((b >> (2*sel_b[p])) & 16'h3))
                        << (2*(sel_a[p] + sel_b[p]));
            end
            if (last_out[p]) done = 1'b1;
        end
        check("last_cycle", c, nn + p + 1);
        tick();
        if (dig_valid[p]) begin
            pulses++;
            if (dig_last[p]) begin
                lasts++;
                check("dig_last_pos", pulses, 2*n);
            end
        end
        check("ready_after", {30'd0, req_ready[p], busy[p]}, {30'd0, 2'b10});
        check("dig_pulses", pulses, 2*n);
        check("dig_last_cnt", lasts, 1);
        if (chk_prod) check("product", prod, exp_prod);
    endtask

    initial begin
        int starts, pos1, pos2, dv;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts, pos1, pos2, dv;
        rst_n = 1'b0;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_a = '0; req_b = '0; req_wcode = '0; req_signed = 1'b0;
        repeat (3) tick();
        check("rst_outs", {start[0], sel_a[0], sel_b[0], cnt_down[0], cnt_last2[0], last_out[0], inv_f[0],
              inv_s[0], place_one[0], cshift[0], init_sum[0], dig_valid[0], dig_last[0], busy[0]}, 32'd0);
        check("rst_ready", {30'd0, req_ready[0], req_ready[1]}, {30'd0, 2'b11});
        check("rst_a_o", 32'(a_o[0]), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(0, 16'd13, 16'd11, 2'd1, 1'b0, 32'd143, 1'b1);
        run_op(0, 16'd3, 16'd3, 2'd0, 1'b0, 32'd9, 1'b1);
        run_op(0, 16'hFFF9, 16'd5, 2'd2, 1'b1, 32'd0, 1'b0);
        run_op(0, 16'hFFFF, 16'hFFFF, 2'd3, 1'b0, 32'hFFFE0001, 1'b1);
        run_op(1, 16'hFFFE, 16'hFFFE, 2'd0, 1'b1, 32'd0, 1'b0);

        // Back-to-back with req_valid held high; operand changes while busy must not be stored.
        req_a = 16'd3; req_b = 16'd2; req_wcode = 2'd0; req_signed = 1'b0;
        req_valid[0] = 1'b1;
        starts = 0; pos1 = 0; pos2 = 0;
        for (int s = 1; s <= 12; s++) begin
            tick();
            if (start[0]) begin
                starts++;
                if (starts == 1) pos1 = s;
                if (starts == 2) begin
                    pos2 = s;
                    req_valid[0] = 1'b0;
                    check("b2b_a_second", 32'(a_o[0]), 32'd1);
                end
            end
            if (s == 1) req_a = 16'd1;
            if (s == 4) check("b2b_a_held", 32'(a_o[0]), 32'd3);
        end
        req_valid[0] = 1'b0;
        check("b2b_starts", starts, 2);
        check("b2b_pos", {pos1[15:0], pos2[15:0]}, {16'd1, 16'd5});

        // Async reset in the middle of a 16b MAC phase.
        req_a = 16'hFFFF; req_b = 16'hFFFF; req_wcode = 2'd3; req_signed = 1'b0;
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        repeat (10) tick();
        check("pre_rst_busy", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_state", {28'd0, req_ready[0], busy[0], dig_valid[0], cnt_last2[0]}, {28'd0, 4'b1000});
        tick();
        rst_n = 1'b1;
        dv = 0;
        for (int s = 0; s < 6; s++) begin
            tick();
            if (dig_valid[0]) dv++;
        end
        check("rst_no_digits", dv, 0);
        check("rst_ready_after", 32'(req_ready[0]), 32'd1);
        run_op(0, 16'd9, 16'd7, 2'd1, 1'b0, 32'd63, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Schedule generator and request handshake placed directly upstream of the digit-serial multiplier datapath.
- Accepts one multiply request: operands, width code and signedness.
- Drives the datapath's operand load, digit mux selects, column-shift, sign-correction and final-output controls.
- Emits a valid/last strobe aligned with each product digit the datapath produces, LSB digit first.

Parameters:
- P, 2, digit width in bits; only 2 is supported.
- MAX_WIDTH, 16, maximum operand width in bits; number of digits NMAX = MAX_WIDTH/P = 8.
- MANUAL_PIPELINE, 0, must match the datapath setting; 1 inserts one product-pipeline cycle.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  high only in IDLE
- req_a_i  in  MAX_WIDTH  operand A, sign-extended to MAX_WIDTH
- req_b_i  in  MAX_WIDTH  operand B, sign-extended to MAX_WIDTH
- req_wcode_i  in  2  operand width: 0→2b, 1→4b, 2→8b, 3→16b
- req_signed_i  in  1  two's-complement operands
- a_o, b_o  out  MAX_WIDTH  operands captured at the handshake
- start_o  out  1  datapath load/clear pulse
- muxSelA_o, muxSelB_o  out  3  digit indices i, j
- countDown_o  out  1  column index k ≥ N-1
- countLast2_o  out  1  last term of current column
- lastOut_o  out  1  final upper-digit cycle
- invertFirstBit_o, invertSecondRow_o  out  1  sign handling
- placeOne_o  out  1  correction-one injection
- countShiftInput_o  out  2  bits shifted into the carry counter
- initSum_o  out  4*P  accumulator preset
- dig_valid_o  out  1  datapath output p holds a product digit
- dig_last_o  out  1  most-significant product digit
- busy_o  out  1  state ≠ IDLE

Behaviour:
- Reset: all outputs 0 except req_ready_o=1; state IDLE.
- N = 1 << req_wcode_i; the product has 2N digits.
- States and transitions:
  - IDLE: req_valid_i & req_ready_o → capture operands, wcode and signed → LOAD.
  - LOAD: one cycle. start_o=1; initSum_o = signed ? INIT_SIGNED : 0 → MAC.
  - MAC: one term per cycle, ordered by column k = 0..2N-2, and within a column by i ascending from max(0,k-N+1) to min(k,N-1). j = k-i.
  - MAC outputs: muxSelA_o=i, muxSelB_o=j. countLast2_o=1 on each column's last term. countDown_o = (k ≥ N-1). MAC lasts exactly N² cycles.
  - After MAC: DRAIN for one cycle if MANUAL_PIPELINE, else go directly to LAST.
  - LAST: lastOut_o=1 for one cycle → IDLE.
- Latency: 1 + N² + MANUAL_PIPELINE + 1 cycles from handshake to return to IDLE. req_ready_o is low throughout.
- Signed mode (Baugh-Wooley):
  - invertFirstBit_o = (i==N-1).
  - invertSecondRow_o = (j==N-1).
  - Both are forced 0 when i==j==N-1 and N>1.
  - placeOne_o=1 on the first term of column N-1.
  - countShiftInput_o = 2'b10 on the countLast2 cycle of column 2N-2, else 0.
  - Unsigned mode: all four of these outputs are 0.
- Pipelined mode: every schedule output except start_o, lastOut_o, initSum_o and the a_o/b_o operands is delayed one cycle by an internal register stage. The datapath therefore sees columns one cycle late; DRAIN absorbs the delay.
- Digit strobe:
  - dig_valid_o pulses one cycle after each datapath shift (delayed countLast2_o) and one cycle after lastOut_o.
  - Exactly 2N pulses per operation; dig_last_o accompanies the final one.
  - dig_valid_o may be asserted in the IDLE cycle following LAST.
- N=1: MAC is one cycle with countLast2_o=1; in signed mode both invert flags are 1.
- req_valid_i while busy: ignored, not stored.
- Async reset mid-operation: immediate IDLE, all strobes 0; no partial digits are flagged afterwards.
- Operands are not range-checked; upper bits beyond the width are don't-care for the datapath.

Decomposition:
- Shared package seq_mult_pkg holds:
  - typedef state_e {IDLE, LOAD, MAC, DRAIN, LAST};
  - wcode_t (2b) and digit_idx_t (3b);
  - constants INIT_SIGNED = 8'h00 (reserved preset) and CORR_SHIFT = 2'b10.
- One natural sub-module, seq_mult_term_cnt: column/term counter producing i, j, k, first-term and last-term flags for a given N.

Test Plan:
- Unsigned 4b: A=4'd13, B=4'd11 → MAC 4 cycles with (i,j)=(0,0),(0,1),(1,0),(1,1). countLast2 in cycles 1, 3, 4. 4 digits streamed form 8'd143.
- Signed 8b: A=-7, B=5 with seq_mult attached → 8 digits = 16'hFFDD, dig_last on the 8th.
- Unsigned 16b: 0xFFFF × 0xFFFF → 64 MAC cycles; product 0xFFFE0001. Exactly 16 dig_valid pulses.
- MANUAL_PIPELINE=1, 2b signed: −2 × −2 → DRAIN present, product 4'd4, latency 4 cycles.
- Back-to-back: req_valid held high → second handshake only in the cycle after LAST. No dropped or duplicated request.
- Reset asserted mid-MAC of a 16b operation → next cycle IDLE, req_ready=1, zero dig_valid. A following 4b request completes correctly.
